// File: rtl/regfile_write_sequencer.sv
// Merges the main datapath (src0) and a FIFO-buffered long-latency source (src1)
// onto the single register-file write port, with a pending-write query for hazard stalls.
module regfile_write_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          src0_valid,
  output logic                          src0_ready,
  input  logic [4:0]                    src0_addr,
  input  logic [31:0]                   src0_data,
  input  logic                          src1_valid,
  output logic                          src1_ready,
  input  logic [4:0]                    src1_addr,
  input  logic [31:0]                   src1_data,
  output logic                          reg_write,
  output logic [4:0]                    write_register,
  output logic [31:0]                   write_data,
  input  logic [4:0]                    query_addr,
  output logic                          query_pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_req_t;

  wr_req_t               mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [SW-1:0]         starve_cnt;

  logic    fifo_empty, fifo_full, force_fifo;
  logic    enq, deq, src0_issue, issue_vld;
  wr_req_t issue;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign force_fifo = !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));
  assign src0_ready = !force_fifo;
  assign src1_ready = !fifo_full;
  assign enq        = src1_valid && !fifo_full;
  assign idle       = fifo_empty && !reg_write;

  always_comb begin
    issue      = '0;
    issue_vld  = 1'b0;
    deq        = 1'b0;
    src0_issue = 1'b0;
    if (force_fifo) begin
      deq       = 1'b1;
      issue_vld = 1'b1;
      issue     = mem[rd_ptr];
    end else if (src0_valid) begin
      src0_issue = 1'b1;
      issue_vld  = 1'b1;
      issue      = '{addr: src0_addr, data: src0_data};
    end else if (!fifo_empty) begin
      deq       = 1'b1;
      issue_vld = 1'b1;
      issue     = mem[rd_ptr];
    end
  end

  // Storage carries no reset; ent_vld alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{addr: src1_addr, data: src1_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      ent_vld        <= '0;
      fifo_count     <= '0;
      starve_cnt     <= '0;
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else begin
      // enq and deq can never target the same slot: one needs non-full, the other non-empty.
      if (deq) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (enq) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (deq || fifo_empty)
        starve_cnt <= '0;
      else if (src0_issue && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
      reg_write <= issue_vld && (issue.addr != 5'd0);
      if (issue_vld) begin
        write_register <= issue.addr;
        write_data     <= issue.data;
      end
    end
  end

  always_comb begin
    query_pending = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_vld[i] && mem[i].addr == query_addr) query_pending = 1'b1;
    if (reg_write && write_register == query_addr) query_pending = 1'b1;
    if (query_addr == 5'd0) query_pending = 1'b0;
  end
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Bench for regfile_write_sequencer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the issue/starvation rules.
module tb_regfile_write_sequencer;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        src0_valid, src0_ready;
  logic [4:0]  src0_addr;
  logic [31:0] src0_data;
  logic        src1_valid, src1_ready;
  logic [4:0]  src1_addr;
  logic [31:0] src1_data;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [4:0]  query_addr;
  logic        query_pending;
  logic [2:0]  fifo_count;
  logic        idle;

  regfile_write_sequencer #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_addr(src0_addr), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_addr(src1_addr), .src1_data(src1_data),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .query_addr(query_addr), .query_pending(query_pending), .fifo_count(fifo_count), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  logic        acc0, acc1;
  bit          chk_en = 0;
  bit          watch6 = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance model across the edge.
  task automatic step(input logic rst, input logic s0v, input logic [4:0] s0a, input logic [31:0] s0d,
                      input logic s1v, input logic [4:0] s1a, input logic [31:0] s1d,
                      input logic [4:0] qa);
    int   cnt;
    bit   frc, hit, iss, pop;
    ent_t ie, head;
    reset = rst; src0_valid = s0v; src0_addr = s0a; src0_data = s0d;
    src1_valid = s1v; src1_addr = s1a; src1_data = s1d; query_addr = qa;
    #1;
    cnt = mq.size();
    frc = (cnt != 0) && (m_starve == LIMIT);
    if (chk_en) begin
      hit = m_rw && (m_wr == qa);
      foreach (mq[i]) if (mq[i].a == qa) hit = 1;
      chk("src0_ready", src0_ready, !frc);
      chk("src1_ready", src1_ready, cnt != DEPTH);
      chk("fifo_count", fifo_count, cnt);
      chk("reg_write", reg_write, m_rw);
      chk("write_register", write_register, m_wr);
      chk("write_data", write_data, m_wd);
      chk("idle", idle, (cnt == 0) && !m_rw);
      chk("query_pending", query_pending, (qa != 0) && hit);
      if (watch6 && reg_write && write_register >= 5'd20 && write_register <= 5'd22)
        chk("flushed_entry_written", write_register, 0);
    end
    acc0 = 0; acc1 = 0; iss = 0; pop = 0; ie = '{a: 0, d: 0};
    if (!rst) begin
      acc1 = s1v && (cnt != DEPTH);
      if (cnt != 0) head = mq[0];
      if (frc) begin pop = 1; ie = head; end
      else if (s0v) begin acc0 = 1; ie = '{a: s0a, d: s0d}; end
      else if (cnt != 0) begin pop = 1; ie = head; end
      iss = pop || acc0;
    end
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_starve = 0; m_rw = 0; m_wr = 0; m_wd = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc1) mq.push_back('{a: s1a, d: s1d});
      if (pop || cnt == 0) m_starve = 0;
      else if (acc0 && m_starve < LIMIT) m_starve++;
      m_rw = iss && (ie.a != 0);
      if (iss) begin m_wr = ie.a; m_wd = ie.d; end
    end
    chk_en = 1;
    @(negedge clk);
  endtask

  task automatic idle_step(input logic [4:0] qa);
    step(0, 0, 0, 0, 0, 0, 0, qa);
  endtask

  initial begin
    int   n0, pushed, maxc;
    logic [4:0] seen[$];
    bit   found;
    m_starve = 0; m_rw = 0; m_wr = 0; m_wd = 0;
    reset = 1; src0_valid = 0; src0_addr = 0; src0_data = 0;
    src1_valid = 0; src1_addr = 0; src1_data = 0; query_addr = 0;
    @(negedge clk);

    // 1: reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_reg_write", reg_write, 0);
    chk("t1_write_register", write_register, 0);
    chk("t1_write_data", write_data, 0);
    chk("t1_src0_ready", src0_ready, 1);
    chk("t1_src1_ready", src1_ready, 1);
    chk("t1_fifo_count", fifo_count, 0);
    chk("t1_idle", idle, 1);

    // 2: single src0 write
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("t2_reg_write", reg_write, 1);
    chk("t2_write_register", write_register, 5);
    chk("t2_write_data", write_data, 32'hDEADBEEF);
    idle_step(0);
    chk("t2_reg_write_after", reg_write, 0);

    // 3: src0 saturating while src1 fills the FIFO
    n0 = 0; pushed = 0; maxc = 0;
    for (int k = 0; k < 30; k++) begin
      step(0, 1, 5'((n0 % 7) + 1), 32'h100 + n0, pushed < 4, 5'(8 + pushed), 32'hA00 + pushed, 0);
      if (acc0) n0++;
      if (acc1) pushed++;
      if (reg_write && write_register >= 8 && write_register <= 11) seen.push_back(write_register);
      if (int'(fifo_count) > maxc) maxc = fifo_count;
      if (fifo_count == 3'd4) chk("t3_src1_ready_full", src1_ready, 0);
    end
    src0_valid = 0;
    chk("t3_max_count", maxc, 4);
    chk("t3_seen_count", seen.size(), 4);
    foreach (seen[i]) chk("t3_order", seen[i], 8 + i);
    idle_step(0);
    idle_step(0);

    // 4: writes to $0 are consumed silently
    chk("t4_src0_ready", src0_ready, 1);
    step(0, 1, 5'd0, 32'h1234, 0, 0, 0, 0);
    chk("t4_src0_acc", acc0, 1);
    chk("t4_reg_write0", reg_write, 0);
    step(0, 0, 0, 0, 1, 5'd0, 32'h55, 0);
    chk("t4_count_after_enq", fifo_count, 1);
    idle_step(0);
    chk("t4_count_after_deq", fifo_count, 0);
    chk("t4_reg_write1", reg_write, 0);

    // 5: pending query for a queued src1 write
    step(0, 1, 5'd3, 32'h33, 1, 5'd9, 32'h99, 5'd9);
    chk("t5_pending_after_acc", query_pending, 1);
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      step(0, 1, 5'd3, 32'h33, 0, 0, 0, 5'd9);
      if (reg_write && write_register == 5'd9) found = 1;
      else chk("t5_pending_hold", query_pending, 1);
    end
    chk("t5_written", found, 1);
    chk("t5_pending_at_write", query_pending, 1);
    step(0, 1, 5'd3, 32'h33, 0, 0, 0, 5'd9);
    chk("t5_pending_after", query_pending, 0);
    step(0, 0, 0, 0, 1, 5'd0, 32'h0, 5'd0);
    chk("t5_query0", query_pending, 0);
    idle_step(0);
    idle_step(0);

    // random traffic
    for (int k = 0; k < 3000; k++)
      step(($urandom % 150) == 0, ($urandom % 10) < 6, 5'($urandom_range(0, 7)), $urandom,
           ($urandom % 2) == 1, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
    for (int k = 0; k < 12; k++) idle_step(0);

    // 6: reset discards queued entries
    step(0, 1, 5'd1, 32'h1, 1, 5'd20, 32'h20, 0);
    step(0, 1, 5'd2, 32'h2, 1, 5'd21, 32'h21, 0);
    step(0, 1, 5'd3, 32'h3, 1, 5'd22, 32'h22, 0);
    chk("t6_count_before", fifo_count, 3);
    watch6 = 1;
    step(1, 1, 5'd4, 32'h4, 0, 0, 0, 0);
    chk("t6_count_after", fifo_count, 0);
    chk("t6_reg_write_after", reg_write, 0);
    for (int k = 0; k < 10; k++) idle_step(5'd21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
